// File: rtl/fir_dac_out.sv
// FIR output stage: 32-bit sum -> 16-bit offset binary -> MSB-first SPI DAC frame.
// Define FIR_DAC_ROUND_EN for round-half-up scaling; otherwise the scale truncates toward -inf.
module fir_dac_out #(
    parameter int unsigned CLK_DIV = 2,
    parameter int unsigned SHIFT   = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        sample_valid,
    input  logic [31:0] fir_data_i,
    output logic        sample_ready,
    output logic        dac_cs_n,
    output logic        dac_sclk,
    output logic        dac_sdo,
    output logic        sat_flag,
    output logic [7:0]  overrun_cnt
);

    localparam int unsigned DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
`ifdef FIR_DAC_ROUND_EN
    localparam logic [32:0] RND = 33'd1 << (SHIFT - 1);
`else
    localparam logic [32:0] RND = '0;
`endif

    typedef enum logic [2:0] {IDLE, SCALE, START, SHIFT_BITS, STOP} state_t;

    state_t             state, next_state;
    logic [DW-1:0]      div_cnt;
    logic               phase;
    logic [3:0]         bit_cnt;
    logic [15:0]        sr;
    logic [31:0]        data;
    logic               accept, div_end, shift_en, clip;
    logic signed [32:0] sum, shifted;
    logic [15:0]        word, scaled;

    assign accept  = sample_valid && sample_ready;
    assign div_end = (div_cnt == DIV_LAST);

    always_comb begin
        sum     = $signed({data[31], data}) + $signed(RND);
        shifted = sum >>> SHIFT;
        clip    = 1'b0;
        word    = shifted[15:0];
        if (shifted > 33'sd32767) begin
            word = 16'h7FFF;
            clip = 1'b1;
        end else if (shifted < -33'sd32768) begin
            word = 16'h8000;
            clip = 1'b1;
        end
        scaled = {~word[15], word[14:0]};
    end

    always_comb begin
        next_state = state;
        shift_en   = 1'b0;
        case (state)
            IDLE:       if (accept) next_state = SCALE;
            SCALE:      next_state = START;
            START:      if (div_end) next_state = SHIFT_BITS;
            SHIFT_BITS: begin
                // falling SCLK edge for every bit but the last moves the next bit up
                shift_en = div_end && !phase && (bit_cnt != 4'd15);
                if (div_end && phase && bit_cnt == 4'd15) next_state = STOP;
            end
            STOP:       if (div_end) next_state = IDLE;
            default:    next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_cnt      <= '0;
            phase        <= 1'b0;
            bit_cnt      <= '0;
            sr           <= '0;
            data         <= '0;
            sat_flag     <= 1'b0;
            overrun_cnt  <= '0;
            sample_ready <= 1'b1;
            dac_cs_n     <= 1'b1;
            dac_sclk     <= 1'b0;
            dac_sdo      <= 1'b0;
        end else begin
            if (accept) data <= fir_data_i;

            if (state == SCALE) begin
                sr       <= scaled;
                sat_flag <= clip;
            end else if (shift_en) begin
                sr <= {sr[14:0], 1'b0};
            end

            if (state != next_state) begin
                div_cnt <= '0;
                phase   <= 1'b0;
                bit_cnt <= '0;
            end else if (state == START || state == SHIFT_BITS || state == STOP) begin
                div_cnt <= div_end ? '0 : div_cnt + 1'b1;
                if (state == SHIFT_BITS && div_end) begin
                    phase <= ~phase;
                    if (phase) bit_cnt <= bit_cnt + 4'd1;
                end
            end

            if (sample_valid && !sample_ready && overrun_cnt != 8'hFF)
                overrun_cnt <= overrun_cnt + 8'd1;

            // pins are a one-cycle registered image of the current state
            sample_ready <= (next_state == IDLE);
            dac_cs_n     <= !(state == START || state == SHIFT_BITS);
            dac_sclk     <= (state == SHIFT_BITS) && !phase;
            dac_sdo      <= (state == START || state == SHIFT_BITS) ? sr[15] : 1'b0;
        end
    end

endmodule

// File: tb/tb_fir_dac_out.sv
// Directed bench for fir_dac_out at default parameters; expectations follow FIR_DAC_ROUND_EN.
module tb_fir_dac_out;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        sample_valid = 1'b0;
    logic [31:0] fir_data_i = '0;
    logic        sample_ready, dac_cs_n, dac_sclk, dac_sdo, sat_flag;
    logic [7:0]  overrun_cnt;

    int vectors = 0;
    int miscompares = 0;

    fir_dac_out #(.CLK_DIV(2), .SHIFT(15)) dut (
        .clk          (clk),
        .reset        (reset),
        .sample_valid (sample_valid),
        .fir_data_i   (fir_data_i),
        .sample_ready (sample_ready),
        .dac_cs_n     (dac_cs_n),
        .dac_sclk     (dac_sclk),
        .dac_sdo      (dac_sdo),
        .sat_flag     (sat_flag),
        .overrun_cnt  (overrun_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic wait_ready();
        for (int i = 0; i < 200; i++) begin
            if (sample_ready) return;
            @(negedge clk);
        end
        check("ready_timeout", {31'd0, sample_ready}, 32'd1);
    endtask

    // One full frame; k counts negedge samples after the accept edge (k=0 right after it).
    task automatic run_frame(input logic [31:0] d, input bit inject,
                             output logic [15:0] word, output int cs_low,
                             output int cs_fall, output int ready_at, output int nbits);
        logic prev;
        word = '0; cs_low = 0; cs_fall = -1; ready_at = -1; nbits = 0; prev = 1'b0;
        @(negedge clk);
        wait_ready();
        sample_valid = 1'b1;
        fir_data_i   = d;
        @(posedge clk);
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (k == 0) begin
                sample_valid = 1'b0;
                fir_data_i   = 32'hDEAD_BEEF;
            end
            if (inject && k == 10) begin
                sample_valid = 1'b1;
                fir_data_i   = 32'h7FFF_FFFF;
            end
            if (inject && k == 11) sample_valid = 1'b0;
            if (!dac_cs_n) begin
                cs_low++;
                if (cs_fall < 0) cs_fall = k;
            end
            if (dac_sclk && !prev) begin
                word = {word[14:0], dac_sdo};
                nbits++;
            end
            prev = dac_sclk;
            if (sample_ready) begin
                ready_at = k;
                break;
            end
        end
    endtask

    logic [15:0] w;
    int cs_low, cs_fall, rdy, nb, rises, rej;
    logic prev_sclk;

    initial begin
        repeat (3) @(negedge clk);
        check("rst_ready", {31'd0, sample_ready}, 32'd1);
        check("rst_cs_n",  {31'd0, dac_cs_n},     32'd1);
        check("rst_sclk",  {31'd0, dac_sclk},     32'd0);
        check("rst_sdo",   {31'd0, dac_sdo},      32'd0);
        check("rst_sat",   {31'd0, sat_flag},     32'd0);
        check("rst_ovr",   {24'd0, overrun_cnt},  32'd0);
        reset = 1'b0;
        @(negedge clk);
        check("rel_ready", {31'd0, sample_ready}, 32'd1);

        run_frame(32'h0000_4000, 1'b0, w, cs_low, cs_fall, rdy, nb);
`ifdef FIR_DAC_ROUND_EN
        check("round_word", {16'd0, w}, 32'h8001);
`else
        check("round_word", {16'd0, w}, 32'h8000);
`endif
        check("round_sat",    {31'd0, sat_flag}, 32'd0);
        check("round_cs_low", 32'(cs_low),  32'd66);
        check("round_cs_lat", 32'(cs_fall), 32'd2);
        check("round_frame",  32'(rdy),     32'd69);
        check("round_bits",   32'(nb),      32'd16);

        run_frame(32'h4000_0000, 1'b0, w, cs_low, cs_fall, rdy, nb);
        check("pclip_word", {16'd0, w}, 32'hFFFF);
        check("pclip_sat",  {31'd0, sat_flag}, 32'd1);
        run_frame(32'h3FFF_8000, 1'b0, w, cs_low, cs_fall, rdy, nb);
        check("pmax_word", {16'd0, w}, 32'hFFFF);
        check("pmax_sat",  {31'd0, sat_flag}, 32'd0);

        run_frame(32'hBFFF_0000, 1'b0, w, cs_low, cs_fall, rdy, nb);
        check("nclip_word", {16'd0, w}, 32'h0000);
        check("nclip_sat",  {31'd0, sat_flag}, 32'd1);
        run_frame(32'hC000_0000, 1'b0, w, cs_low, cs_fall, rdy, nb);
        check("nmin_word", {16'd0, w}, 32'h0000);
        check("nmin_sat",  {31'd0, sat_flag}, 32'd0);

        run_frame(32'h1234_5678, 1'b1, w, cs_low, cs_fall, rdy, nb);
`ifdef FIR_DAC_ROUND_EN
        check("ovr_word", {16'd0, w}, 32'hA469);
`else
        check("ovr_word", {16'd0, w}, 32'hA468);
`endif
        check("ovr_cnt",   {24'd0, overrun_cnt}, 32'd1);
        check("ovr_frame", 32'(rdy), 32'd69);
        check("ovr_bits",  32'(nb),  32'd16);
        check("ovr_sat",   {31'd0, sat_flag}, 32'd0);

        // reset while SCLK is high for bit index 5
        @(negedge clk);
        wait_ready();
        sample_valid = 1'b1;
        fir_data_i   = 32'h1234_0000;
        @(negedge clk);
        sample_valid = 1'b0;
        rises = 0;
        prev_sclk = 1'b0;
        for (int k = 0; k < 200 && rises < 6; k++) begin
            @(negedge clk);
            if (dac_sclk && !prev_sclk) rises++;
            prev_sclk = dac_sclk;
        end
        check("mid_reached", 32'(rises), 32'd6);
        reset = 1'b1;
        #1;
        check("mid_cs_n", {31'd0, dac_cs_n}, 32'd1);
        check("mid_sclk", {31'd0, dac_sclk}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("mid_ready", {31'd0, sample_ready}, 32'd1);
        check("mid_ovr",   {24'd0, overrun_cnt},  32'd0);
        run_frame(32'h0000_0000, 1'b0, w, cs_low, cs_fall, rdy, nb);
        check("mid_new_word", {16'd0, w}, 32'h8000);
        check("mid_new_bits", 32'(nb), 32'd16);

        // continuous strobe: every cycle not in IDLE is a rejected sample
        @(negedge clk);
        wait_ready();
        rej = 0;
        sample_valid = 1'b1;
        fir_data_i   = 32'h0001_0000;
        for (int i = 0; i < 400; i++) begin
            if (!sample_ready) rej++;
            @(negedge clk);
        end
        sample_valid = 1'b0;
        check("sat_rejects_ge300", {31'd0, rej >= 300}, 32'd1);
        check("sat_cnt", {24'd0, overrun_cnt}, 32'd255);
        repeat (150) @(negedge clk);
        check("sat_hold", {24'd0, overrun_cnt}, 32'd255);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("sat_clear", {24'd0, overrun_cnt}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got running, expected finished");
        $fatal(1);
    end

endmodule
